// File: rtl/wramp_alu_mc.sv
// Multi-cycle WRAMP ALU: single-cycle logic ops, iterative unsigned multiply/divide.
// Define WRAMP_ALU_DIV_EN to build the restoring divider (func 7 divu, func 9 remu).
module wramp_alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] FuncAdd  = 4'd0;
    localparam logic [3:0] FuncSub  = 4'd2;
    localparam logic [3:0] FuncMulu = 4'd5;
    localparam logic [3:0] FuncAnd  = 4'd11;
    localparam logic [3:0] FuncOr   = 4'd13;
    localparam logic [3:0] FuncLhi  = 4'd14;
    localparam logic [3:0] FuncXor  = 4'd15;
`ifdef WRAMP_ALU_DIV_EN
    localparam logic [3:0] FuncDivu = 4'd7;
    localparam logic [3:0] FuncRemu = 4'd9;
`endif

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    // Holds the multiplier in MUL and the (unshifted) divisor in DIV.
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
`ifdef WRAMP_ALU_DIV_EN
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic                   rem_sel_q, rem_sel_d;
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH:0]         rem_diff;
    logic                   rem_ge;
`endif

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        div_zero_d = div_zero_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
`ifdef WRAMP_ALU_DIV_EN
        rem_d      = rem_q;
        quo_d      = quo_q;
        rem_sel_d  = rem_sel_q;
        rem_sh     = {rem_q, quo_q[WIDTH-1]};
        // MSB of the difference is clear exactly when the shifted remainder >= divisor.
        rem_diff   = rem_sh - {1'b0, mplier_q};
        rem_ge     = ~rem_diff[WIDTH];
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    state_d    = StFin;
                    case (func)
                        FuncAdd: out_d = a + b;
                        FuncSub: out_d = a - b;
                        FuncAnd: out_d = a & b;
                        FuncOr:  out_d = a | b;
                        FuncXor: out_d = a ^ b;
                        FuncLhi: out_d = b << (WIDTH / 2);
                        FuncMulu: begin
                            state_d  = StMul;
                            prod_d   = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                            cnt_d    = CntW'(WIDTH);
                        end
`ifdef WRAMP_ALU_DIV_EN
                        FuncDivu, FuncRemu: begin
                            if (b == '0) begin
                                out_d      = (func == FuncDivu) ? '1 : a;
                                div_zero_d = 1'b1;
                            end else begin
                                state_d   = StDiv;
                                rem_d     = '0;
                                quo_d     = a;
                                mplier_d  = b;
                                rem_sel_d = (func == FuncRemu);
                                cnt_d     = CntW'(WIDTH);
                            end
                        end
`endif
                        default: out_d = '0;
                    endcase
                end
            end

            StMul: begin
                prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFin;
                    out_d   = prod_d[WIDTH-1:0];
                end
            end

`ifdef WRAMP_ALU_DIV_EN
            StDiv: begin
                rem_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFin;
                    out_d   = rem_sel_q ? rem_d : quo_d;
                end
            end
`endif

            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            out_q      <= '0;
            div_zero_q <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
`ifdef WRAMP_ALU_DIV_EN
            rem_q      <= '0;
            quo_q      <= '0;
            rem_sel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            div_zero_q <= div_zero_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
`ifdef WRAMP_ALU_DIV_EN
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            rem_sel_q  <= rem_sel_d;
`endif
        end
    end

    assign out      = out_q;
    assign div_zero = div_zero_q;
    assign done     = (state_q == StFin);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_wramp_alu_mc.sv
// Directed self-checking bench for wramp_alu_mc (WIDTH=32), with or without WRAMP_ALU_DIV_EN.
module tb_wramp_alu_mc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        done;
    logic        busy;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

`ifdef WRAMP_ALU_DIV_EN
    localparam logic [3:0] LongFunc = 4'd7;
`else
    localparam logic [3:0] LongFunc = 4'd5;
`endif

    wramp_alu_mc #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .func     (func),
        .a        (a),
        .b        (b),
        .out      (out),
        .done     (done),
        .busy     (busy),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge (edge k); returns #1 after edge k, i.e. in cycle k+1.
    task automatic go(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        func  = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, optionally poke start in the done cycle, then step one cycle.
    task automatic run(input int lat0, input bit poke, output int lat, output int bc,
                       output logic [31:0] o, output logic dz,
                       output logic post_busy, output logic post_done);
        lat = lat0;
        bc  = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) bc++;
            if (done) break;
            @(posedge clk);
            #1;
            lat++;
        end
        o  = out;
        dz = div_zero;
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            func  = 4'd13;
            a     = 32'hF0;
            b     = 32'h0F;
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        post_busy = busy;
        post_done = done;
    endtask

    task automatic op(input string tag, input logic [3:0] f, input logic [31:0] x,
                      input logic [31:0] y, input int exp_lat, input logic [31:0] exp_out,
                      input logic exp_dz);
        int          lat, bc;
        logic [31:0] o;
        logic        dz, pb, pd;
        go(f, x, y);
        run(1, 1'b0, lat, bc, o, dz, pb, pd);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, bc, exp_lat);
        chk({tag, "_out"}, o, exp_out);
        chk({tag, "_div_zero"}, dz, exp_dz);
        chk({tag, "_idle_after"}, {pb, pd}, 2'b00);
    endtask

    initial begin
        int          lat, bc, npulse;
        logic [31:0] o;
        logic        dz, pb, pd;

        rst   = 1'b1;
        start = 1'b0;
        func  = 4'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 32'h0);
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 1, 32'h0000_0000, 1'b0);
        op("lhi", 4'd14, 32'h0, 32'h1234, 1, 32'h1234_0000, 1'b0);

        // out must hold its old value while the multiply runs
        go(4'd5, 32'h0001_0000, 32'h0001_0001);
        chk("mul_out_held", out, 32'h1234_0000);
        run(1, 1'b0, lat, bc, o, dz, pb, pd);
        chk("mul1_lat", lat, 33);
        chk("mul1_busy_cycles", bc, 33);
        chk("mul1_out", o, 32'h0001_0000);
        chk("mul1_idle_after", {pb, pd}, 2'b00);

        op("mul_ones", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 1'b0);

        // start during busy and start in the done cycle are both ignored
        go(4'd5, 32'd3, 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        func  = 4'd0;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run(5, 1'b1, lat, bc, o, dz, pb, pd);
        chk("ign_lat", lat, 33);
        chk("ign_out", o, 32'd15);
        chk("ign_busy_cycles", bc, 29);
        chk("ign_done_cycle_start", {pb, pd}, 2'b00);
        chk("ign_out_held", out, 32'd15);

        // reset in the middle of a long operation
        go(LongFunc, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_out", out, 32'h0);
        chk("rst_mid_div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) npulse++;
        end
        chk("rst_mid_no_done", npulse, 0);
        op("or_after_rst", 4'd13, 32'hF0, 32'h0F, 1, 32'hFF, 1'b0);

        op("sub", 4'd2, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0);
        op("and", 4'd11, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 1'b0);
        op("xor", 4'd15, 32'hFF00_FF00, 32'hF0F0_F0F0, 1, 32'h0FF0_0FF0, 1'b0);
        op("unsup3", 4'd3, 32'h1234_5678, 32'h1, 1, 32'h0, 1'b0);
        op("mul_small", 4'd5, 32'd12345, 32'd678, 33, 32'd8369910, 1'b0);

`ifdef WRAMP_ALU_DIV_EN
        op("divu", 4'd7, 32'd100, 32'd7, 33, 32'd14, 1'b0);
        op("remu", 4'd9, 32'd100, 32'd7, 33, 32'd2, 1'b0);
        op("divu_zero", 4'd7, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
        op("remu_zero", 4'd9, 32'd100, 32'd0, 1, 32'd100, 1'b1);
        op("dz_cleared", 4'd0, 32'd1, 32'd1, 1, 32'd2, 1'b0);
        op("remu_big", 4'd9, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32'h7FFF_FFFF, 1'b0);
        op("divu_big", 4'd7, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32'h1, 1'b0);
        op("divu_one", 4'd7, 32'hDEAD_BEEF, 32'd1, 33, 32'hDEAD_BEEF, 1'b0);
`else
        op("divu_off", 4'd7, 32'd100, 32'd7, 1, 32'h0, 1'b0);
        op("remu_off_zero", 4'd9, 32'd100, 32'd0, 1, 32'h0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wramp_alu_mc.md
# wramp_alu_mc

Parametrised multi-cycle ALU for the WRAMP datapath, the successor to the current combinational ALU with its bolted-on shift-add multiplier. Logic ops complete in one registered cycle. Unsigned multiply, divide and remainder run as iterative sequences behind an explicit start/busy/done handshake. Sits between the register-file read stage and the writeback mux; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width; even, >= 8.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  accept `func`/`a`/`b` this cycle; honoured only when `busy`=0.
- `func`  in  4  operation code (WRAMP func field).
- `a`  in  WIDTH  operand A (rs).
- `b`  in  WIDTH  operand B (rt/immediate).
- `out`  out  WIDTH  registered result; held until next accepted start.
- `done`  out  1  one-cycle pulse, `out` valid that cycle.
- `busy`  out  1  high from cycle after accepted start through the `done` cycle.
- `div_zero`  out  1  registered with `done`; set when div/rem had `b`=0.

## Operation
- States: IDLE, MUL, DIV, FIN. Reset -> IDLE, `out`=0, `done`=0, `busy`=0, `div_zero`=0.
- IDLE + `start`: latch `func`, `a`, `b`; `div_zero` cleared.
  - 0 add `a+b`; 2 sub `a-b`; 11 and; 13 or; 15 xor; 14 lhi `b << (WIDTH/2)`. All modulo 2^WIDTH. -> FIN with result.
  - 5 multu: -> MUL; `prod`(2*WIDTH)=0, `mcand`=`a` zero-extended, `mplier`=`b`.
  - 7 divu (quotient), 9 remu (remainder): `b`=0 -> FIN, `out`= all-ones for 7, `a` for 9, `div_zero`=1. Else -> DIV with restoring divider, `rem`=0, `quo`=`a`.
  - Any other code: -> FIN, `out`=0.
- MUL: per cycle, if `mplier[0]` add `mcand` to `prod`; `mcand`<<=1; `mplier`>>=1; counter decrements from WIDTH. Counter 0 -> FIN, `out`=`prod[WIDTH-1:0]`.
- DIV: per cycle shift {`rem`,`quo`} left 1; if `rem`>=`b`, `rem`-=`b`, `quo[0]`=1. WIDTH iterations -> FIN, `out`=`quo` (7) or `rem` (9).
- FIN: `done`=1 for exactly one cycle, `busy`=1 that cycle, -> IDLE.
- `start` while `busy`: ignored, no state change, no error.
- `start` in same cycle as `done`: ignored (`busy` still high); caller re-asserts next cycle.
- `rst` mid-operation: next edge -> IDLE, all outputs to reset values; partial results discarded.
- `out` changes only on the FIN-entry edge; it is stable at all other times.

## Timing
- Start sampled at edge k.
- Single-cycle ops, unsupported codes, div-by-zero: `done` high in cycle k+1; `busy` high in cycle k+1 only.
- multu: MUL for WIDTH cycles; `done` in cycle k+WIDTH+1 (k+33 at WIDTH=32).
- divu/remu: same, `done` in cycle k+WIDTH+1.
- Earliest next accepted start is edge k+latency+1. Throughput: one op per latency+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `WRAMP_ALU_DIV_EN` defined: DIV state, divider datapath and func 7/9 as above.
- Undefined: no divider logic is synthesised; func 7/9 behave as unsupported codes (`out`=0, one-cycle `done`, `div_zero`=0). All other behaviour is unchanged.

## Test plan
- Reset, then start func 0 with `a`=0xFFFFFFFF, `b`=1 -> `done` in k+1, `out`=0x00000000; func 14 with `b`=0x1234 -> `out`=0x12340000.
- Start func 5 with `a`=0x0001_0000, `b`=0x0001_0001 -> `busy` for 33 cycles, `done` at k+33, `out`=0x00010000. Repeat with `a`=`b`=0xFFFFFFFF -> `out`=0x00000001.
- With `WRAMP_ALU_DIV_EN`: func 7 `a`=100, `b`=7 -> `out`=14 at k+33; func 9 same operands -> `out`=2; func 7 `b`=0 -> k+1, `out`=0xFFFFFFFF, `div_zero`=1.
- During a multu, pulse `start` with func 0 at cycle k+5 -> ignored; result and `done` timing unchanged; `start` asserted in the `done` cycle is also ignored.
- Assert `rst` at cycle k+10 of a divu -> next cycle `busy`=0, `done`=0, `out`=0; a fresh func 13 `a`=0xF0, `b`=0x0F then returns 0xFF at k'+1.
- Without the macro: func 7 `a`=100, `b`=7 -> `done` at k+1, `out`=0, `div_zero`=0.
